// File: rtl/life_engine_rowpar.sv
// life_engine_rowpar
//   Game-of-Life engine holding a WIDTH x HEIGHT board as row words. A STEP
//   computes one complete next row per clock into a shadow board, waits for
//   the display to permit a commit, then copies the shadow board over the
//   visible one a row per clock. The birth/survive rule and the edge handling
//   (torus or dead border) are programmable per operation.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_op            0=STEP 1=RANDOMIZE 2=CLEAR 3=LOAD_ROW
//   cmd_row/cmd_data  target row and contents for LOAD_ROW
//   run               enables the free-running auto-step timer
//   commit_ok         permits copying the new generation (tie to vblank)
//   wrap              1=torus, 0=cells outside the board are dead
//   rule_birth        bit n: dead cell with n neighbours becomes alive
//   rule_survive      bit n: live cell with n neighbours stays alive
//   rd_row/rd_data    combinational read of the visible board
//   busy, done        engine not idle / one-cycle completion pulse
//   gen_count         generations since last RANDOMIZE/CLEAR
//   population        live cells after last STEP/RANDOMIZE/CLEAR
module life_engine_rowpar #(
    parameter int LOG_W    = 5,
    parameter int LOG_H    = 4,
    parameter int INTERVAL = 2400000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [LOG_H-1:0]         cmd_row,
    input  logic [(1<<LOG_W)-1:0]    cmd_data,
    input  logic                     run,
    input  logic                     commit_ok,
    input  logic                     wrap,
    input  logic [8:0]               rule_birth,
    input  logic [8:0]               rule_survive,
    input  logic [LOG_H-1:0]         rd_row,
    output logic [(1<<LOG_W)-1:0]    rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              gen_count,
    output logic [LOG_W+LOG_H:0]     population
);
    localparam int WIDTH  = 1 << LOG_W;
    localparam int HEIGHT = 1 << LOG_H;
    localparam int CNT_W  = LOG_W + LOG_H;
    localparam int POP_W  = CNT_W + 1;
    localparam int TMR_W  = $clog2(INTERVAL);

    localparam logic [1:0] OP_STEP  = 2'd0;
    localparam logic [1:0] OP_RAND  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_LOAD  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_UPDATE, S_WAIT_COMMIT, S_COPY, S_FILL, S_CLEAR, S_LOAD
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [LOG_H-1:0]   row;
    logic [TMR_W-1:0]   timer;
    logic [15:0]        lfsr;
    logic [POP_W-1:0]   pop_acc;
    logic               start, tick, row_last, fill_last;

    logic               wrap_l;
    logic [8:0]         birth_l, surv_l;
    logic [LOG_H-1:0]   load_row;
    logic [WIDTH-1:0]   load_data;

    logic [WIDTH-1:0]   cur [HEIGHT];
    logic [WIDTH-1:0]   nxt [HEIGHT];

    logic [WIDTH-1:0]   up_w, md_w, dn_w, new_row;
    logic [WIDTH+1:0]   up_x, md_x, dn_x;
    logic [LOG_W:0]     row_pop;
    logic [3:0]         n;

    // Neighbour count of one cell from the three cells above, the three
    // below and the two horizontal neighbours.
    function automatic logic [3:0] nbr_count(input logic [2:0] above,
                                             input logic [2:0] below,
                                             input logic       left,
                                             input logic       right);
        return 4'(above[0]) + 4'(above[1]) + 4'(above[2]) +
               4'(below[0]) + 4'(below[1]) + 4'(below[2]) +
               4'(left) + 4'(right);
    endfunction

    // Row-sequential operations use the low bits of the counter as row index;
    // FILL uses the whole counter as a row-major cell index.
    assign row       = cnt[LOG_H-1:0];
    assign row_last  = (row == LOG_H'(HEIGHT - 1));
    assign fill_last = (cnt == {CNT_W{1'b1}});
    assign rd_data   = cur[rd_row];

    // A command always beats a simultaneous timer expiry.
    assign tick  = (state == S_IDLE) && run && !cmd_valid &&
                   (timer == TMR_W'(INTERVAL - 1));
    assign start = (state == S_IDLE) && (cmd_valid || tick);

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_STEP:  state_nx = S_UPDATE;
                        OP_RAND:  state_nx = S_FILL;
                        OP_CLEAR: state_nx = S_CLEAR;
                        OP_LOAD:  state_nx = S_LOAD;
                        default:  state_nx = S_IDLE;
                    endcase
                end else if (tick) begin
                    state_nx = S_UPDATE;
                end
            end
            S_UPDATE:      if (row_last)  state_nx = S_WAIT_COMMIT;
            S_WAIT_COMMIT: if (commit_ok) state_nx = S_COPY;
            S_COPY:        if (row_last)  state_nx = S_IDLE;
            S_FILL:        if (fill_last) state_nx = S_IDLE;
            S_CLEAR:       if (row_last)  state_nx = S_IDLE;
            S_LOAD:                       state_nx = S_IDLE;
            default:                      state_nx = S_IDLE;
        endcase
    end

    // Next-row computation. Each source row is padded with one column on
    // either side: the wrapped-around cell in torus mode, a dead cell otherwise.
    always_comb begin
        up_w    = (!wrap_l && row == '0) ? '0 : cur[row - LOG_H'(1)];
        md_w    = cur[row];
        dn_w    = (!wrap_l && row_last) ? '0 : cur[row + LOG_H'(1)];
        up_x    = {wrap_l & up_w[0], up_w, wrap_l & up_w[WIDTH-1]};
        md_x    = {wrap_l & md_w[0], md_w, wrap_l & md_w[WIDTH-1]};
        dn_x    = {wrap_l & dn_w[0], dn_w, wrap_l & dn_w[WIDTH-1]};
        new_row = '0;
        row_pop = '0;
        n       = '0;
        for (int x = 0; x < WIDTH; x++) begin
            n          = nbr_count(up_x[x +: 3], dn_x[x +: 3], md_x[x], md_x[x+2]);
            new_row[x] = md_w[x] ? surv_l[n] : birth_l[n];
            row_pop    = row_pop + {{LOG_W{1'b0}}, new_row[x]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FILL;
            cnt        <= '0;
            timer      <= '0;
            lfsr       <= 16'hACE1;
            pop_acc    <= '0;
            done       <= 1'b0;
            gen_count  <= '0;
            population <= '0;
        end else begin
            state <= state_nx;
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cnt   <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
            timer <= (state == S_IDLE && run && !start) ? timer + TMR_W'(1) : '0;
            done  <= (state != S_IDLE) && (state_nx == S_IDLE);

            if (start)
                pop_acc <= '0;
            else if (state == S_UPDATE)
                pop_acc <= pop_acc + {{LOG_H{1'b0}}, row_pop};
            else if (state == S_FILL)
                pop_acc <= pop_acc + {{CNT_W{1'b0}}, lfsr[0]};

            if (state == S_COPY && row_last) begin
                gen_count  <= gen_count + 16'd1;
                population <= pop_acc;
            end
            if (state == S_FILL && fill_last) begin
                gen_count  <= '0;
                population <= pop_acc + {{CNT_W{1'b0}}, lfsr[0]};
            end
            if (state == S_CLEAR && row_last) begin
                gen_count  <= '0;
                population <= '0;
            end
        end
    end

    // Board storage and per-operation latches; contents are not reset.
    always_ff @(posedge clk) begin
        if (start) begin
            wrap_l    <= wrap;
            birth_l   <= rule_birth;
            surv_l    <= rule_survive;
            load_row  <= cmd_row;
            load_data <= cmd_data;
        end
        case (state)
            S_UPDATE: nxt[row] <= new_row;
            S_COPY:   cur[row] <= nxt[row];
            S_FILL:   cur[cnt[CNT_W-1:LOG_W]][cnt[LOG_W-1:0]] <= lfsr[0];
            S_CLEAR:  cur[row] <= '0;
            S_LOAD:   cur[load_row] <= load_data;
            default:  ;
        endcase
    end

endmodule
